// File: rtl/maxpool_stream_if.sv
// Pixel-in / pooled-value-out stream bundle for maxpool_stream.
// master: the producer of pixels (and consumer of pooled values).
// slave:  the pooling block itself.
interface maxpool_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;

  modport master (
    output valid_in,
    output data_in,
    input  valid_out,
    input  data_out,
    input  frame_done
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output valid_out,
    output data_out,
    output frame_done
  );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming KxK / stride-K max pooling over one raster-ordered channel.
// A running horizontal max covers the current K-pixel group of a row; a
// line buffer with one entry per group carries the partial column max
// down through the K rows of a window band. One pooled value is emitted
// one cycle after the bottom-right pixel of each window.
// Optional build macro MAXPOOL_SIGNED_EN: all max() comparisons treat
// pixels as two's-complement; otherwise they are unsigned.
module maxpool_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 2,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic              Clk,
  input  logic              Rst,
  maxpool_stream_if.slave   bus
);

  localparam int GROUPS = (K >= 1) ? (IMG_W / K) : 1;
  localparam int CW     = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
  localparam int RW     = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
  localparam int KW     = (K      > 1) ? $clog2(K)      : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (K < 1) begin : g_bad_k
    $error("maxpool_stream: K must be at least 1");
  end
  if ((K >= 1) && (IMG_W % K != 0)) begin : g_bad_w
    $error("maxpool_stream: IMG_W must be a multiple of K");
  end
  if ((K >= 1) && (IMG_H % K != 0)) begin : g_bad_h
    $error("maxpool_stream: IMG_H must be a multiple of K");
  end

  // Ties return the shared value, so the result never needs extra width.
  function automatic logic [DATA_WIDTH-1:0] pick_max(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [KW-1:0]         wcol;
  logic [KW-1:0]         wrow;
  logic [GW-1:0]         grp;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] line_buf [GROUPS];

  logic                  win_first_col;
  logic                  win_last_col;
  logic                  win_first_row;
  logic                  win_last_row;
  logic                  row_end;
  logic                  frame_end;
  logic [DATA_WIDTH-1:0] h;
  logic [DATA_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] pool;

  // Window position decode and the running horizontal / vertical max.
  always_comb begin
    win_first_col = (wcol == '0);
    win_last_col  = (wcol == KW'(K - 1));
    win_first_row = (wrow == '0);
    win_last_row  = (wrow == KW'(K - 1));
    row_end       = (col == CW'(IMG_W - 1));
    frame_end     = row_end && (row == RW'(IMG_H - 1));
    h             = win_first_col ? bus.data_in : pick_max(hmax, bus.data_in);
    buf_rd        = line_buf[grp];
    // With K=1 the line buffer is never part of a window.
    pool          = (K == 1) ? h : pick_max(buf_rd, h);
  end

  // Partial column max per group; the first row of a band overwrites, so
  // no reset is needed and nothing leaks from an earlier frame.
  always_ff @(posedge Clk) begin
    if (bus.valid_in && win_last_col && !win_last_row) begin
      line_buf[grp] <= win_first_row ? h : pick_max(buf_rd, h);
    end
  end

  // Raster position counters, horizontal max register and pooled output.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col            <= '0;
      row            <= '0;
      wcol           <= '0;
      wrow           <= '0;
      grp            <= '0;
      hmax           <= '0;
      bus.data_out   <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.valid_in) begin
        hmax <= h;
        col  <= row_end ? '0 : col + 1'b1;
        wcol <= win_last_col ? '0 : wcol + 1'b1;
        if (win_last_col) begin
          // The last group of a row always coincides with the row end.
          grp <= row_end ? '0 : grp + 1'b1;
        end
        if (row_end) begin
          wrow <= win_last_row ? '0 : wrow + 1'b1;
          row  <= frame_end ? '0 : row + 1'b1;
        end
        if (win_last_col && win_last_row) begin
          bus.data_out   <= pool;
          bus.valid_out  <= 1'b1;
          bus.frame_done <= frame_end;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: a 2x2 over 4x4 instance driven from a vector
// table and a 3x3 over 6x6 instance driven with back-to-back frames.
// Expected pooled values are queued when the window's last pixel is
// driven and checked (value, frame_done, arrival cycle) when they appear.
`timescale 1ns/1ps
module tb_maxpool_stream;

  typedef struct {
    logic [15:0][7:0] pix;
    logic [3:0][7:0]  exp;
    bit               gaps;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       fd;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;
  int   b_fd_cnt;
  logic [7:0] last_out [2];
  exp_t qa[$];
  exp_t qb[$];
  vec_t tbl[5];

  maxpool_stream_if #(.DATA_WIDTH(8)) ifa ();
  maxpool_stream_if #(.DATA_WIDTH(8)) ifb ();

  maxpool_stream #(.DATA_WIDTH(8), .K(2), .IMG_W(4), .IMG_H(4)) u_a (
    .Clk (clk),
    .Rst (rst_n),
    .bus (ifa)
  );

  maxpool_stream #(.DATA_WIDTH(8), .K(3), .IMG_W(6), .IMG_H(6)) u_b (
    .Clk (clk),
    .Rst (rst_n),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, id, got, want);
    end
  endtask

  task automatic check_port(input int id, input logic v, input logic [7:0] d,
                            input logic fd);
    exp_t e;
    bit   have;
    if (fd) chk("frame_done_with_valid", id, {31'd0, v}, 32'd1);
    if (v) begin
      have = (id == 0) ? (qa.size() > 0) : (qb.size() > 0);
      n_checks++;
      if (!have) begin
        n_err++;
        $display("FAIL unexpected_out[%0d]: got pulse with data %0h, expected no pulse", id, d);
      end else begin
        if (id == 0) e = qa.pop_front();
        else         e = qb.pop_front();
        chk("data_out", id, {24'd0, d}, {24'd0, e.d});
        chk("frame_done", id, {31'd0, fd}, {31'd0, e.fd});
        chk("latency_cycle", id, cyc, e.cyc);
      end
      if (id == 1 && fd) b_fd_cnt++;
      last_out[id] = d;
    end else begin
      chk("data_hold", id, {24'd0, d}, {24'd0, last_out[id]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_port(0, ifa.valid_out, ifa.data_out, ifa.frame_done);
      check_port(1, ifb.valid_out, ifb.data_out, ifb.frame_done);
    end else begin
      last_out[0] = 8'h00;
      last_out[1] = 8'h00;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ifa.valid_in = 1'b0;
      ifb.valid_in = 1'b0;
    end
  endtask

  // Drives the first npix pixels of a 4x4 frame into instance A.
  task automatic feed_a(input vec_t v, input int npix);
    int   r, c, k;
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      k = 0;
      while (v.gaps && ($urandom_range(0, 1) == 1) && (k < 4)) begin
        @(posedge clk); #1;
        ifa.valid_in = 1'b0;
        k++;
      end
      @(posedge clk); #1;
      ifa.valid_in = 1'b1;
      ifa.data_in  = v.pix[i];
      r = i / 4;
      c = i % 4;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.d   = v.exp[(r / 2) * 2 + (c / 2)];
        e.fd  = (i == 15);
        e.cyc = cyc + 1;
        qa.push_back(e);
      end
    end
  endtask

  // Back-to-back 6x6 frames of 0..35 into instance B, windows max-reduced here.
  task automatic feed_b(input int nfr);
    int         r, c;
    logic [7:0] m;
    exp_t       e;
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 36; i++) begin
        @(posedge clk); #1;
        ifb.valid_in = 1'b1;
        ifb.data_in  = 8'(i);
        r = i / 6;
        c = i % 6;
        if ((r % 3 == 2) && (c % 3 == 2)) begin
          m = 8'h00;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              if (8'((r - dr) * 6 + (c - dc)) > m) m = 8'((r - dr) * 6 + (c - dc));
          e.d   = m;
          e.fd  = (r == 5) && (c == 5);
          e.cyc = cyc + 1;
          qb.push_back(e);
        end
      end
    end
  endtask

  initial begin
    // Vector table: 0 raster, 1 signed/unsigned, 2 descending, 3 raster gapped, 4 post-reset.
    for (int i = 0; i < 16; i++) begin
      tbl[0].pix[i] = 8'(i);
      tbl[2].pix[i] = 8'(15 - i);
      tbl[4].pix[i] = 8'h03;
      case ({(i / 4) % 2, (i % 4) % 2})
        2'b00:   tbl[1].pix[i] = 8'h80;
        2'b01:   tbl[1].pix[i] = 8'h01;
        2'b10:   tbl[1].pix[i] = 8'h7F;
        default: tbl[1].pix[i] = 8'hFF;
      endcase
    end
    tbl[4].pix[5] = 8'h09;
    tbl[0].exp = {8'd15, 8'd13, 8'd7, 8'd5};
`ifdef MAXPOOL_SIGNED_EN
    tbl[1].exp = {8'h7F, 8'h7F, 8'h7F, 8'h7F};
`else
    tbl[1].exp = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
    tbl[2].exp = {8'd5, 8'd7, 8'd13, 8'd15};
    tbl[4].exp = {8'h03, 8'h03, 8'h03, 8'h09};
    tbl[3]      = tbl[0];
    tbl[0].gaps = 1'b0;
    tbl[1].gaps = 1'b0;
    tbl[2].gaps = 1'b0;
    tbl[3].gaps = 1'b1;
    tbl[4].gaps = 1'b0;

    cyc = 0; n_checks = 0; n_err = 0; b_fd_cnt = 0;
    last_out[0] = 8'h00;
    last_out[1] = 8'h00;
    rst_n = 1'b0;
    ifa.valid_in = 1'b0; ifa.data_in = 8'h00;
    ifb.valid_in = 1'b0; ifb.data_in = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_out", 0, {31'd0, ifa.valid_out}, 32'd0);
    chk("reset_data_out", 0, {24'd0, ifa.data_out}, 32'd0);
    chk("reset_frame_done", 0, {31'd0, ifa.frame_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle after reset: outputs stay quiet.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_valid_out", 0, {31'd0, ifa.valid_out}, 32'd0);
      chk("idle_data_out", 0, {24'd0, ifa.data_out}, 32'd0);
      chk("idle_frame_done", 0, {31'd0, ifa.frame_done}, 32'd0);
      chk("idle_valid_out", 1, {31'd0, ifb.valid_out}, 32'd0);
    end

    // Table frames, back-to-back on instance A.
    for (int t = 0; t < 4; t++) feed_a(tbl[t], 16);
    idle(4);

    // Mid-frame reset: six raster pixels (completing window 0), then reset.
    feed_a(tbl[0], 6);
    idle(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_data_out", 0, {24'd0, ifa.data_out}, 32'd0);
    chk("midreset_valid_out", 0, {31'd0, ifa.valid_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    feed_a(tbl[4], 16);
    idle(4);

    // Generalised geometry, two frames with no bubble.
    feed_b(2);
    idle(6);

    chk("pending_a", 0, qa.size(), 32'd0);
    chk("pending_b", 1, qb.size(), 32'd0);
    chk("frame_done_count", 1, b_fd_cnt, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming KxK max-pooling with stride K for one raster-ordered feature-map channel.
- One pixel is accepted per valid_in beat, with no backpressure.
- A horizontal running max and a (IMG_W/K)-entry partial-max line buffer produce one pooled value per window.
- Sits between a convolution/activation stage and the next layer's input; generalises the fixed 2x2 pooler in kernel size, width and image geometry.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- K, 2, window size and stride (K >= 1).
- IMG_W, 28, input row length in pixels; must be a multiple of K, enforced by an elaboration-time error.
- IMG_H, 28, input rows per frame; must be a multiple of K, enforced by an elaboration-time error.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in carries the next raster pixel this cycle.
- data_in  input  DATA_WIDTH  input pixel.
- valid_out  output  1  data_out holds a new pooled value (one-cycle pulse per value).
- data_out  output  DATA_WIDTH  pooled value.
- frame_done  output  1  pulses together with the last valid_out of a frame.

Behaviour:
- Reset (Rst=0, asynchronous):
  - col, wcol, row, wrow counters = 0; hmax = 0.
  - data_out = 0, valid_out = 0, frame_done = 0.
  - Line buffer is not reset; it is never read before being written in a frame.
- Counters advance only on valid_in=1:
  - col 0..IMG_W-1; wcol = col mod K.
  - row 0..IMG_H-1; wrow = row mod K.
  - All wrap to 0 after the last pixel of a frame.
  - valid_in=0 cycles freeze all state; gaps of any length are legal.
- Horizontal max, per beat: h = (wcol==0) ? data_in : max(hmax, data_in); hmax <= h.
- On a beat with wcol==K-1, group index g = col/K:
  - wrow==0: buf[g] <= h.
  - 0<wrow<K-1: buf[g] <= max(buf[g], h).
  - wrow==K-1: data_out <= max(buf[g], h) and valid_out <= 1 on the next edge. With K=1, data_out <= h.
- Latency: valid_out is high exactly one cycle after the beat carrying the window's bottom-right pixel.
- valid_out is low in all other cycles; data_out holds its last value while valid_out=0.
- Outputs per frame: (IMG_W/K)*(IMG_H/K), in raster order of windows.
- frame_done=1 in the same cycle as valid_out for the final window (row=IMG_H-1, col=IMG_W-1 beat).
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle right after the last pixel of frame N. No bubble is required and no state leaks between frames.
- Compare: max() is unsigned by default; see Optional Feature. Ties return the equal value, so no width growth occurs.
- Reset mid-frame: all partial results are discarded; the next valid_in beat is treated as pixel (0,0) of a new frame.
- No throughput limit: one pixel per cycle sustained.

Optional Feature:
- Macro: MAXPOOL_SIGNED_EN.
- Defined: all max() comparisons treat operands as two's-complement signed DATA_WIDTH values.
- Undefined: comparisons are unsigned.
- Datapath width and latency are identical in both builds.

Test Plan:
- Reset/idle: K=2, IMG_W=4, IMG_H=4, DATA_WIDTH=8; hold Rst=0, then release with valid_in=0 for 10 cycles -> valid_out=0, data_out=0, frame_done=0 throughout.
- Basic 2x2: feed 0..15 raster, one per cycle -> valid_out pulses with 5, 7, 13, 15. Each pulse comes one cycle after the inputs 5, 7, 13, 15 respectively. frame_done accompanies 15.
- Gapped input: same frame with valid_in randomly low about 50% of cycles -> identical output sequence 5, 7, 13, 15. Each output is one cycle after its triggering beat; there are exactly 4 pulses.
- Signed/unsigned: 2x2 frame of 0x80, 0x01, 0x7F, 0xFF:
  - Without MAXPOOL_SIGNED_EN -> 0xFF.
  - With MAXPOOL_SIGNED_EN -> 0x7F.
- Mid-frame reset then new frame: assert Rst=0 after 6 pixels; release, then feed a 4x4 frame of all 0x03 except pixel (1,1)=0x09 -> outputs 0x09, 0x03, 0x03, 0x03, with no stale values.
- Generalised geometry, back-to-back: K=3, IMG_W=6, IMG_H=6; two consecutive frames of 0..35 with no gap -> each frame outputs 14, 17, 32, 35. frame_done appears twice.
